udma_filter_tx_datain: RTL
==========================

# udma_filter_tx_datain

Source-side DMA engine of the uDMA filter. It issues read requests on the uDMA TX channel and generates L2 addresses in linear, 2D-row or 2D-column patterns. Returned data is buffered and forwarded as a valid/ready stream, with frame markers, into the filter datapath. It is the read counterpart of the filter's RX data-out engine and uses the same cfg_* programming model.

## Interface
- DATA_WIDTH, 32, stream/channel data width
- L2_AWIDTH_NOAL, 15, L2 address width
- BUFFER_DEPTH, 4, data FIFO depth; also the maximum number of outstanding requests
- TRANS_SIZE, 16, counter/length width
- clk_i  in  1  clock
- resetn_i  in  1  reset, asynchronous, active-low
- tx_ch_req_o  out  1  read request
- tx_ch_addr_o  out  L2_AWIDTH_NOAL  request address
- tx_ch_datasize_o  out  2  equals cfg_datasize_i
- tx_ch_gnt_i  in  1  request accepted
- tx_ch_valid_i  in  1  read data valid, returned in request order
- tx_ch_data_i  in  DATA_WIDTH  read data
- tx_ch_ready_o  out  1  always 1 after reset (space is guaranteed by credits)
- cmd_start_i  in  1  start pulse; sampled only in IDLE
- cmd_done_o  out  1  one-cycle pulse when the last element leaves the stream
- cfg_start_addr_i  in  L2_AWIDTH_NOAL  base address
- cfg_datasize_i  in  2  00 byte, 01 half, 10 word, 11 step 0
- cfg_mode_i  in  2  0 LINEAR, 1 2D_ROW, 2 2D_COL
- cfg_len0_i, cfg_len1_i  in  TRANS_SIZE  last inner/outer index (count-1)
- cfg_len2_i  in  TRANS_SIZE  stride in bytes
- stream_data_o  out  DATA_WIDTH; stream_sof_o, stream_eof_o  out  1  frame markers
- stream_valid_o  out  1; stream_ready_i  in  1

## Operation
- FSM states:
  - IDLE: on cmd_start_i, latch mode, start address, pointer = cfg_start_addr_i, w = l = 0; go to REQ.
  - REQ: tx_ch_req_o = (credits > 0). On req&gnt, the address steps per mode. On the grant of the last element, go to DRAIN.
  - DRAIN: when the element with eof is popped (stream_valid_o & stream_ready_i), pulse cmd_done_o and go to IDLE.
- Step size: datasize 00→1, 01→2, 10→4, 11→0.
- LINEAR: len0+1 elements; pointer += step. The last element is w == len0.
- 2D_ROW: len1+1 rows of len0+1 elements.
  - Within a row, pointer += step.
  - At w == len0: w = 0, l++, rowstart += len2, pointer = new rowstart.
  - Last element: w == len0 && l == len1.
- 2D_COL: len0+1 columns of len1+1 elements.
  - Within a column, pointer += len2.
  - At l == len1: l = 0, w++, colstart += step, pointer = new colstart.
  - Last element: same condition as 2D_ROW.
- Credits:
  - Reset value is BUFFER_DEPTH.
  - Decrement on req&gnt; increment on stream pop.
  - Both in the same cycle: unchanged.
- Tags: on each grant, push {sof = first element, eof = last element} into the tag FIFO. On each tx_ch_valid_i, pop the tag FIFO and push {tag, data} into the data FIFO.
- stream_* outputs are driven from the data FIFO head.
- cfg_* inputs other than mode and start address are read live and must stay stable while busy.
- cmd_start_i outside IDLE is ignored.

## Timing
- Reset values:
  - Outputs: req 0, addr 0, stream_valid 0, sof/eof 0, cmd_done 0, tx_ch_ready 1.
  - Internal: FSM IDLE; credits BUFFER_DEPTH; both FIFOs empty.
- First request is asserted the cycle after cmd_start_i.
- Back-to-back grants: one request per cycle while credits > 0.
- Channel data to stream_valid_o: 1 cycle (registered FIFO).
- Address arithmetic wraps modulo 2^L2_AWIDTH_NOAL; len2 is truncated to the address width.
- Credits reach 0: req drops the same cycle; it resumes the cycle after a pop.
- A single-element transfer (len0 = len1 = 0) carries sof = eof = 1 on the same beat.
- Reset mid-operation: all state returns to reset values. In-flight read data arriving after reset is dropped, because the FIFOs are empty and the tag FIFO is cleared.

## Structure
- Shared package udma_filter_pkg:
  - MODE_LINEAR/MODE_2D_ROW/MODE_2D_COL constants.
  - State enum.
  - Datasize-to-step function, shared with the RX data-out engine.
- Sub-module: io_generic_fifo, instantiated twice:
  - 2-bit tag FIFO.
  - DATA_WIDTH+2 data FIFO.

## Test plan
- LINEAR, start 0x100, datasize 10, len0 = 3 → addresses 0x100, 0x104, 0x108, 0x10C. The 4 beats carry sof on beat 0 and eof on beat 3. cmd_done_o pulses once.
- 2D_ROW, start 0x0, datasize 00, len0 = 1, len1 = 2, len2 = 0x10 → addresses 0x0, 0x1, 0x10, 0x11, 0x20, 0x21.
- 2D_COL, start 0x40, datasize 01, len0 = 1, len1 = 1, len2 = 0x20 → addresses 0x40, 0x60, 0x42, 0x62.
- stream_ready_i held 0, BUFFER_DEPTH = 4, len0 = 9 → exactly 4 grants, then req stays 0. Releasing ready delivers all 10 elements in order with no loss.
- Grant delayed 3 cycles per request and data returned with random latency → the data sequence matches the expected memory model. cmd_start_i issued mid-transfer is ignored.
- resetn_i asserted mid-transfer in 2D_ROW → outputs return to reset values. A following LINEAR command completes correctly.

Source files
------------

// File: rtl/udma_filter_pkg.sv
// Shared definitions for the uDMA filter data engines: address modes,
// engine state encoding and the datasize-to-step helper.
package udma_filter_pkg;

  localparam logic [1:0] MODE_LINEAR = 2'd0;
  localparam logic [1:0] MODE_2D_ROW = 2'd1;
  localparam logic [1:0] MODE_2D_COL = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // Byte increment per element; datasize 11 holds the pointer in place.
  function automatic logic [2:0] datasize_to_step(input logic [1:0] datasize);
    logic [2:0] step;
    case (datasize)
      2'b00:   step = 3'd1;
      2'b01:   step = 3'd2;
      2'b10:   step = 3'd4;
      default: step = 3'd0;
    endcase
    return step;
  endfunction

endpackage

// File: rtl/io_generic_fifo.sv
// Small synchronous FIFO with valid/ready on both sides; the head entry is
// read straight from the storage registers.
module io_generic_fifo #(
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned BUFFER_DEPTH = 4
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  clr_i,
  input  logic                  valid_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  output logic                  ready_o,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  ready_i
);

  localparam int unsigned PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(BUFFER_DEPTH + 1);

  logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_cnt;

  logic w_push;
  logic w_pop;

  assign ready_o = (r_cnt != CNT_W'(BUFFER_DEPTH));
  assign valid_o = (r_cnt != '0);
  assign data_o  = r_mem[r_rptr];
  assign w_push  = valid_i && ready_o;
  assign w_pop   = valid_o && ready_i;

  // Storage write; cleared so the head reads zero when empty after reset.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int unsigned i = 0; i < BUFFER_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_push) begin
      r_mem[r_wptr] <= data_i;
    end
  end

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else if (clr_i) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= (r_rptr == PTR_W'(BUFFER_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + CNT_W'(1);
        2'b01:   r_cnt <= r_cnt - CNT_W'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/udma_filter_tx_datain.sv
// Source-side DMA engine of the uDMA filter: issues TX channel reads in
// linear / 2D-row / 2D-column patterns and streams the returned data with
// frame markers. Outstanding reads are bounded by a credit counter so the
// data FIFO can never overflow.
module udma_filter_tx_datain
  import udma_filter_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned L2_AWIDTH_NOAL = 15,
  parameter int unsigned BUFFER_DEPTH   = 4,
  parameter int unsigned TRANS_SIZE     = 16
) (
  input  logic                      clk_i,
  input  logic                      resetn_i,

  output logic                      tx_ch_req_o,
  output logic [L2_AWIDTH_NOAL-1:0] tx_ch_addr_o,
  output logic [1:0]                tx_ch_datasize_o,
  input  logic                      tx_ch_gnt_i,
  input  logic                      tx_ch_valid_i,
  input  logic [DATA_WIDTH-1:0]     tx_ch_data_i,
  output logic                      tx_ch_ready_o,

  input  logic                      cmd_start_i,
  output logic                      cmd_done_o,

  input  logic [L2_AWIDTH_NOAL-1:0] cfg_start_addr_i,
  input  logic [1:0]                cfg_datasize_i,
  input  logic [1:0]                cfg_mode_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len0_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len1_i,
  input  logic [TRANS_SIZE-1:0]     cfg_len2_i,

  output logic [DATA_WIDTH-1:0]     stream_data_o,
  output logic                      stream_sof_o,
  output logic                      stream_eof_o,
  output logic                      stream_valid_o,
  input  logic                      stream_ready_i
);

  localparam int unsigned AW   = L2_AWIDTH_NOAL;
  localparam int unsigned CR_W = $clog2(BUFFER_DEPTH + 1);
  localparam int unsigned DF_W = DATA_WIDTH + 2;

  state_e                r_state;
  logic [1:0]            r_mode;
  logic [AW-1:0]         r_ptr;
  logic [AW-1:0]         r_base;
  logic [TRANS_SIZE-1:0] r_w;
  logic [TRANS_SIZE-1:0] r_l;
  logic [CR_W-1:0]       r_credits;
  logic                  r_done;

  logic [AW-1:0]   w_step;
  logic [AW-1:0]   w_stride;
  logic            w_w_end;
  logic            w_l_end;
  logic            w_last;
  logic            w_first;
  logic            w_grant;
  logic            w_pop;
  logic            w_tag_ready;
  logic            w_tag_valid;
  logic [1:0]      w_tag_in;
  logic [1:0]      w_tag_out;
  logic            w_data_ready;
  logic            w_data_push;
  logic            w_data_valid;
  logic [DF_W-1:0] w_data_in;
  logic [DF_W-1:0] w_data_out;

  assign w_step   = AW'(datasize_to_step(cfg_datasize_i));
  assign w_stride = AW'(cfg_len2_i);
  assign w_w_end  = (r_w == cfg_len0_i);
  assign w_l_end  = (r_l == cfg_len1_i);
  assign w_last   = ((r_mode == MODE_2D_ROW) || (r_mode == MODE_2D_COL)) ? (w_w_end && w_l_end) : w_w_end;
  assign w_first  = (r_w == '0) && (r_l == '0);

  assign tx_ch_req_o      = (r_state == ST_REQ) && (r_credits != '0) && w_tag_ready;
  assign tx_ch_addr_o     = r_ptr;
  assign tx_ch_datasize_o = cfg_datasize_i;
  assign tx_ch_ready_o    = 1'b1;
  assign cmd_done_o       = r_done;

  assign w_grant = tx_ch_req_o && tx_ch_gnt_i;
  assign w_pop   = w_data_valid && stream_ready_i;

  // Tag = {sof, eof} recorded at grant, re-joined with data in return order.
  assign w_tag_in    = {w_first, w_last};
  assign w_data_push = tx_ch_valid_i && w_tag_valid && w_data_ready;
  assign w_data_in   = {w_tag_out, tx_ch_data_i};

  assign stream_valid_o = w_data_valid;
  assign stream_sof_o   = w_data_out[DF_W-1];
  assign stream_eof_o   = w_data_out[DF_W-2];
  assign stream_data_o  = w_data_out[DATA_WIDTH-1:0];

  // Sequencer: command latch, address walk and end-of-frame completion.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_state <= ST_IDLE;
      r_mode  <= MODE_LINEAR;
      r_ptr   <= '0;
      r_base  <= '0;
      r_w     <= '0;
      r_l     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (cmd_start_i) begin
            r_mode  <= cfg_mode_i;
            r_ptr   <= cfg_start_addr_i;
            r_base  <= cfg_start_addr_i;
            r_w     <= '0;
            r_l     <= '0;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (w_grant) begin
            case (r_mode)
              MODE_2D_ROW: begin
                if (w_w_end) begin
                  r_w    <= '0;
                  r_l    <= r_l + TRANS_SIZE'(1);
                  r_base <= r_base + w_stride;
                  r_ptr  <= r_base + w_stride;
                end else begin
                  r_w   <= r_w + TRANS_SIZE'(1);
                  r_ptr <= r_ptr + w_step;
                end
              end
              MODE_2D_COL: begin
                if (w_l_end) begin
                  r_l    <= '0;
                  r_w    <= r_w + TRANS_SIZE'(1);
                  r_base <= r_base + w_step;
                  r_ptr  <= r_base + w_step;
                end else begin
                  r_l   <= r_l + TRANS_SIZE'(1);
                  r_ptr <= r_ptr + w_stride;
                end
              end
              default: begin
                r_w   <= r_w + TRANS_SIZE'(1);
                r_ptr <= r_ptr + w_step;
              end
            endcase
            if (w_last) r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (w_pop && stream_eof_o) begin
            r_done  <= 1'b1;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // Credits track free data FIFO slots not yet claimed by an outstanding read.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      r_credits <= CR_W'(BUFFER_DEPTH);
    end else begin
      case ({w_grant, w_pop})
        2'b10:   r_credits <= r_credits - CR_W'(1);
        2'b01:   r_credits <= r_credits + CR_W'(1);
        default: r_credits <= r_credits;
      endcase
    end
  end

  io_generic_fifo #(
    .DATA_WIDTH   (2),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) i_tag_fifo (
    .clk_i   (clk_i),
    .rstn_i  (resetn_i),
    .clr_i   (1'b0),
    .valid_i (w_grant),
    .data_i  (w_tag_in),
    .ready_o (w_tag_ready),
    .valid_o (w_tag_valid),
    .data_o  (w_tag_out),
    .ready_i (tx_ch_valid_i && w_data_ready)
  );

  io_generic_fifo #(
    .DATA_WIDTH   (DF_W),
    .BUFFER_DEPTH (BUFFER_DEPTH)
  ) i_data_fifo (
    .clk_i   (clk_i),
    .rstn_i  (resetn_i),
    .clr_i   (1'b0),
    .valid_i (w_data_push),
    .data_i  (w_data_in),
    .ready_o (w_data_ready),
    .valid_o (w_data_valid),
    .data_o  (w_data_out),
    .ready_i (stream_ready_i)
  );

endmodule
